// File: rtl/fpu_fp16_to_int_pkg.sv
// Shared fp16 types and constants for the fp16 -> integer converter.
// Build option: FPU_CVT_SATURATE_EN selects saturating results on invalid/overflow.
package fpu_fp16_to_int_pkg;

  localparam int FP16_W = 16;
  localparam int FP16_EXPW = 5;
  localparam int FP16_FRACW = 10;
  localparam int FP16_BIAS = 15;
  // Exponent at which the lsb of the 11-bit significand has weight 1.
  localparam int FP16_CVT_UNITY_EXP = FP16_BIAS + FP16_FRACW;
  localparam int FP16_CVT_MAX_RSHIFT = 13;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXPW-1:0]  exp;
    logic [FP16_FRACW-1:0] frac;
  } fp16_t;

  typedef struct packed {
    logic of;
    logic uf;
    logic nx;
  } opStatusFlag_t;

  typedef enum logic [1:0] {
    CVT_IDLE  = 2'd0,
    CVT_SHIFT = 2'd1,
    CVT_ROUND = 2'd2,
    CVT_DONE  = 2'd3
  } cvtState_t;

  function automatic logic cvtShiftLeft(input logic [FP16_EXPW-1:0] e);
    return (e != '1) && (int'(e) > FP16_CVT_UNITY_EXP);
  endfunction

  // Right shifts beyond 13 only move zeros through guard, so they are capped.
  function automatic logic [3:0] cvtShiftCount(input logic [FP16_EXPW-1:0] e);
    int d;
    d = FP16_CVT_UNITY_EXP - int'(e);
    if (e == '1) return 4'd0;
    if (d < 0) begin
      d = -d;
      return d[3:0];
    end
    if (d > FP16_CVT_MAX_RSHIFT) d = FP16_CVT_MAX_RSHIFT;
    return d[3:0];
  endfunction

endpackage

// File: rtl/fpu_cvt_rounder.sv
// Combinational RNE increment, sign application, range check and result select.
// FPU_CVT_SATURATE_EN: clamp invalid/overflow results instead of returning 0.
module fpu_cvt_rounder
  import fpu_fp16_to_int_pkg::*;
#(
  parameter int INTW = 32,
  parameter int MAGW = 33
) (
  input  logic [MAGW-1:0] magnitude,
  input  logic            guard,
  input  logic            sticky,
  input  logic            sign,
  input  logic            signedOut,
  input  logic            special,
  output logic [INTW-1:0] intOut,
  output logic [2:0]      flags
);

  localparam logic [MAGW-1:0] ONE = {{(MAGW-1){1'b0}}, 1'b1};
  localparam logic [MAGW-1:0] SMAX = (ONE << (INTW-1)) - ONE;
  localparam logic [MAGW-1:0] UMAX = (ONE << INTW) - ONE;
  localparam logic [MAGW-1:0] SMIN_MAG = ONE << (INTW-1);

  logic            inc;
  logic [MAGW-1:0] rMag;
  logic            ovf;
  logic [INTW-1:0] trunc;
  logic [INTW-1:0] satVal;
  opStatusFlag_t   f;

  always_comb begin
    inc = guard & (sticky | magnitude[0]);
    rMag = magnitude + {{(MAGW-1){1'b0}}, inc};
    trunc = rMag[INTW-1:0];
    // Negative values are legal unsigned only when they round to zero.
    if (sign) ovf = signedOut ? (rMag > SMIN_MAG) : (rMag != '0);
    else      ovf = rMag > (signedOut ? SMAX : UMAX);
`ifdef FPU_CVT_SATURATE_EN
    if (sign) satVal = signedOut ? {1'b1, {(INTW-1){1'b0}}} : '0;
    else      satVal = signedOut ? {1'b0, {(INTW-1){1'b1}}} : '1;
`else
    satVal = '0;
`endif
    f = '0;
    if (special || ovf) begin
      intOut = satVal;
      f.of = 1'b1;
    end else begin
      intOut = sign ? (-trunc) : trunc;
      f.nx = guard | sticky;
    end
    flags = f;
  end

endmodule

// File: rtl/fpu_fp16_to_int.sv
// Multi-cycle fp16 -> integer converter: one significand bit per cycle, then RNE.
// FPU_CVT_SATURATE_EN (in fpu_cvt_rounder) selects saturating invalid/overflow results.
module fpu_fp16_to_int
  import fpu_fp16_to_int_pkg::*;
#(
  parameter int INTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inValid,
  output logic            inReady,
  input  logic [15:0]     fpIn,
  input  logic            signedOut,
  output logic            outValid,
  input  logic            outReady,
  output logic [INTW-1:0] intOut,
  output logic [2:0]      flags,
  output logic [1:0]      dbgState
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid holds its payload stable until then, ready may change freely.

  // Wide enough for sign-free overflow detection and for sig << 5 (16 bits) plus carry.
  localparam int MAGW = (INTW + 1 > 17) ? INTW + 1 : 17;

  cvtState_t       state;
  fp16_t           fpOp;
  logic [MAGW-1:0] acc;
  logic [3:0]      cnt;
  logic            shiftLeft;
  logic            guard;
  logic            sticky;
  logic            sign;
  logic            signedReg;
  logic            special;
  logic [3:0]      loadCnt;
  logic            isNaN;
  logic [INTW-1:0] rndInt;
  logic [2:0]      rndFlags;

  assign fpOp = fpIn;
  assign loadCnt = cvtShiftCount(fpOp.exp);
  assign isNaN = (fpOp.exp == '1) && (fpOp.frac != '0);
  assign dbgState = state;

  fpu_cvt_rounder #(.INTW(INTW), .MAGW(MAGW)) uRounder (
    .magnitude(acc),
    .guard(guard),
    .sticky(sticky),
    .sign(sign),
    .signedOut(signedReg),
    .special(special),
    .intOut(rndInt),
    .flags(rndFlags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CVT_IDLE;
      inReady <= 1'b0;
      outValid <= 1'b0;
      intOut <= '0;
      flags <= '0;
      acc <= '0;
      cnt <= '0;
      shiftLeft <= 1'b0;
      guard <= 1'b0;
      sticky <= 1'b0;
      sign <= 1'b0;
      signedReg <= 1'b0;
      special <= 1'b0;
    end else begin
      case (state)
        CVT_IDLE: begin
          inReady <= 1'b1;
          if (inValid && inReady) begin
            inReady <= 1'b0;
            // NaN saturates towards the positive limit regardless of its sign bit.
            sign <= fpOp.sign & ~isNaN;
            signedReg <= signedOut;
            special <= (fpOp.exp == '1);
            acc <= {{(MAGW-11){1'b0}}, (fpOp.exp != '0), fpOp.frac};
            cnt <= loadCnt;
            shiftLeft <= cvtShiftLeft(fpOp.exp);
            guard <= 1'b0;
            sticky <= 1'b0;
            state <= (loadCnt == 4'd0) ? CVT_ROUND : CVT_SHIFT;
          end
        end
        CVT_SHIFT: begin
          if (shiftLeft) begin
            acc <= acc << 1;
          end else begin
            acc <= acc >> 1;
            guard <= acc[0];
            sticky <= sticky | guard;
          end
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= CVT_ROUND;
        end
        CVT_ROUND: begin
          intOut <= rndInt;
          flags <= rndFlags;
          outValid <= 1'b1;
          state <= CVT_DONE;
        end
        CVT_DONE: begin
          if (outReady) begin
            outValid <= 1'b0;
            inReady <= 1'b1;
            state <= CVT_IDLE;
          end
        end
        default: state <= CVT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_fp16_to_int.sv
// Scoreboard bench for fpu_fp16_to_int: two instances (INTW=32, INTW=16) in lockstep.
module tb_fpu_fp16_to_int;

  localparam int INTW_A = 32;
  localparam int INTW_B = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic [15:0] fpIn = '0;
  logic        signedOut = 1'b0;
  logic        outReady = 1'b1;

  logic              inReadyA, outValidA, inReadyB, outValidB;
  logic [INTW_A-1:0] intOutA;
  logic [INTW_B-1:0] intOutB;
  logic [2:0]        flagsA, flagsB;
  logic [1:0]        dbgA, dbgB;

  fpu_fp16_to_int #(.INTW(INTW_A)) dutA (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReadyA), .fpIn(fpIn),
    .signedOut(signedOut), .outValid(outValidA), .outReady(outReady), .intOut(intOutA),
    .flags(flagsA), .dbgState(dbgA)
  );

  fpu_fp16_to_int #(.INTW(INTW_B)) dutB (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReadyB), .fpIn(fpIn),
    .signedOut(signedOut), .outValid(outValidB), .outReady(outReady), .intOut(intOutB),
    .flags(flagsB), .dbgState(dbgB)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] val;
    logic [2:0]  flg;
    int          lat;
    int          acc;
    int          hold;
  } exp_t;

  exp_t exp_qA[$];
  exp_t exp_qB[$];
  int   nChecks = 0;
  int   nFails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact value = sig * 2^e, rounded to nearest even with integer arithmetic.
  task automatic ref_model(input logic [15:0] fp, input logic sgn, input int w,
                           output logic [63:0] val, output logic [2:0] flg, output int n);
    int     e, sh, d;
    longint one, sig, mag, q, rem, half, v, hi, lo, satv;
    bit     nx, of;
    one = 1;
    e = int'(fp[14:10]);
    sig = (e != 0 ? 1024 : 0) + longint'(fp[9:0]);
    if (e == 31)      n = 0;
    else if (e > 25)  n = e - 25;
    else if (e >= 1)  n = (25 - e > 13) ? 13 : 25 - e;
    else              n = 13;
    sh = (e == 0) ? -24 : e - 25;
    nx = 0;
    if (sh >= 0) begin
      mag = sig << sh;
    end else begin
      d = -sh;
      q = sig >> d;
      rem = sig - (q << d);
      half = one << (d - 1);
      mag = q + ((rem > half || (rem == half && q[0])) ? 1 : 0);
      nx = (rem != 0);
    end
    v = fp[15] ? -mag : mag;
    if (sgn) begin
      hi = (one << (w - 1)) - 1;
      lo = -(one << (w - 1));
    end else begin
      hi = (one << w) - 1;
      lo = 0;
    end
    of = 0;
    satv = 0;
    if (e == 31) begin
      of = 1;
      satv = (fp[9:0] != 0) ? hi : (fp[15] ? lo : hi);
    end else if (v > hi) begin
      of = 1;
      satv = hi;
    end else if (v < lo) begin
      of = 1;
      satv = lo;
    end
    if (of) begin
      flg = 3'b100;
`ifdef FPU_CVT_SATURATE_EN
      val = satv;
`else
      val = 0;
`endif
    end else begin
      flg = {2'b00, nx};
      val = v;
    end
    val = val & ((64'd1 << w) - 64'd1);
  endtask

  // ---------------- driver ----------------
  task automatic convert(input logic [15:0] fp, input logic sgn, input int hold);
    exp_t eA, eB;
    int   n;
    bit   got;
    got = 0;
    ref_model(fp, sgn, INTW_A, eA.val, eA.flg, n);
    eA.lat = n + 2;
    eA.hold = hold;
    ref_model(fp, sgn, INTW_B, eB.val, eB.flg, n);
    eB.lat = n + 2;
    eB.hold = hold;
    @(negedge clk);
    fpIn = fp;
    signedOut = sgn;
    inValid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      if (inReadyA) begin
        eA.acc = cyc + 1;
        eB.acc = cyc + 1;
        exp_qA.push_back(eA);
        exp_qB.push_back(eB);
        got = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
    // Junk operand while busy must be ignored.
    @(negedge clk);
    inValid = 1'($urandom_range(0, 1));
    fpIn = 16'($urandom);
    signedOut = 1'($urandom_range(0, 1));
    @(negedge clk);
    inValid = 1'b0;
  endtask

  // ---------------- monitors ----------------
  exp_t curA, curB;
  bit   busyA = 0, busyB = 0;
  int   vCntA = 0, vCntB = 0, holdA = 0;

  always @(negedge clk) begin
    if (rst_n && outValidA) begin
      if (!busyA) begin
        if (exp_qA.size() == 0) begin
          check("unexpected_outValidA", 64'd1, 64'd0);
        end else begin
          curA = exp_qA.pop_front();
          busyA = 1;
          vCntA = 0;
          holdA = curA.hold;
          check("intOutA", 64'(intOutA), curA.val);
          check("flagsA", 64'(flagsA), 64'(curA.flg));
          check("latencyA", 64'(cyc + 1 - curA.acc), 64'(curA.lat));
        end
      end else begin
        check("stableIntOutA", 64'(intOutA), curA.val);
        check("stableFlagsA", 64'(flagsA), 64'(curA.flg));
      end
      check("inReadyBusyA", 64'(inReadyA), 64'd0);
      vCntA++;
      if (holdA > 0) begin
        outReady = 1'b0;
        holdA--;
      end else begin
        outReady = 1'b1;
      end
    end else begin
      if (busyA) begin
        check("pulseLenA", 64'(vCntA), 64'(curA.hold + 1));
        busyA = 0;
      end
      outReady = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && outValidB) begin
      if (!busyB) begin
        if (exp_qB.size() == 0) begin
          check("unexpected_outValidB", 64'd1, 64'd0);
        end else begin
          curB = exp_qB.pop_front();
          busyB = 1;
          vCntB = 0;
          check("intOutB", 64'(intOutB), curB.val);
          check("flagsB", 64'(flagsB), 64'(curB.flg));
          check("latencyB", 64'(cyc + 1 - curB.acc), 64'(curB.lat));
        end
      end else begin
        check("stableIntOutB", 64'(intOutB), curB.val);
      end
      vCntB++;
    end else if (busyB) begin
      check("pulseLenB", 64'(vCntB), 64'(curB.hold + 1));
      busyB = 0;
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] dirFp[12] = '{16'h3C00, 16'h3E00, 16'h4100, 16'h4300, 16'hC500, 16'hC500,
                             16'h7C00, 16'h7BFF, 16'hFC00, 16'h7E00, 16'hB800, 16'hBA00};
  logic        dirSg[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                             1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    // Reset values.
    #2;
    check("rst_outValidA", 64'(outValidA), 64'd0);
    check("rst_inReadyA", 64'(inReadyA), 64'd0);
    check("rst_intOutA", 64'(intOutA), 64'd0);
    check("rst_flagsA", 64'(flagsA), 64'd0);
    check("rst_inReadyB", 64'(inReadyB), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_inReadyA", 64'(inReadyA), 64'd1);

    for (int i = 0; i < 12; i++) convert(dirFp[i], dirSg[i], 0);
    // Subnormal with the consumer stalling for 5 cycles.
    convert(16'h0001, 1'b1, 5);
    convert(16'h4000, 1'b1, 2);

    // Reset in the middle of a 1.0 conversion.
    convert(16'h3C00, 1'b1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_qA.delete();
    exp_qB.delete();
    #1;
    check("midrst_outValidA", 64'(outValidA), 64'd0);
    check("midrst_inReadyA", 64'(inReadyA), 64'd0);
    check("midrst_intOutA", 64'(intOutA), 64'd0);
    repeat (3) @(negedge clk);
    check("midrst_hold_outValidA", 64'(outValidA), 64'd0);
    check("midrst_hold_inReadyB", 64'(inReadyB), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_inReadyA", 64'(inReadyA), 64'd1);
    convert(16'h4000, 1'b1, 0);

    // Randomized operands, signedness, consumer stalls and idle gaps.
    for (int i = 0; i < 150; i++) begin
      convert(16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain.
    for (int t = 0; t < 2000 && (exp_qA.size() != 0 || busyA); t++) @(negedge clk);
    check("drain_queueA", 64'(exp_qA.size()), 64'd0);
    check("drain_queueB", 64'(exp_qB.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fpu_fp16_to_int.md
# fpu_fp16_to_int

Multi-cycle converter from packed half-precision (`fp16_t`) to a two's-complement or unsigned integer. It is the unpacking direction of the FPU normalizer path: the normalizer packs sign/exponent/significand into fp16, and this block unpacks fp16 and denormalizes it to a fixed integer. The significand is shifted one bit per cycle, then rounded round-to-nearest-even, range-checked and flagged. Sits at the FPU result port for FCVT-style operations, with a valid/ready handshake on both sides.

## Interface
- `INTW`, 32: output integer width; legal range 8..64.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inValid`  in  1  operand valid.
- `inReady`  out  1  high only in IDLE.
- `fpIn`  in  16  fp16 operand (`fp16_t`).
- `signedOut`  in  1  1 = signed result, 0 = unsigned; captured with `fpIn`.
- `outValid`  out  1  result valid; held until accepted.
- `outReady`  in  1  consumer accepts the result.
- `intOut`  out  INTW  converted integer.
- `flags`  out  3  `opStatusFlag_t` {OF, UF, NX}. OF = invalid or out of range, UF = always 0, NX = inexact.

## Operation
- FSM `cvtState_t`: IDLE → SHIFT → ROUND → DONE → IDLE.
- IDLE: accept when `inValid && inReady`. Capture sign, `signedOut`, and load the significand `sig = {exp!=0, frac}`.
  - Compute shift count N:
    - exp==31 (NaN/inf): special, N=0.
    - exp>25: left shift, N = exp−25 (max 5).
    - 1≤exp≤25: right shift, N = min(25−exp, 13).
    - exp==0: right, N = 13.
  - Clear guard and sticky.
- SHIFT: one bit per cycle.
  - Right shift: sticky |= guard, then guard = bit shifted out.
  - Left shift: zero-fill.
  - Decrement N. Go to ROUND when N reaches 0. If N==0 at accept, go directly to ROUND.
- ROUND, single cycle:
  - Increment magnitude if `guard && (sticky || lsb)`.
  - NX = guard | sticky.
  - Negate if sign.
  - Range check:
    - signed: −2^(INTW−1) .. 2^(INTW−1)−1.
    - unsigned: 0 .. 2^INTW−1. A negative value that rounds to 0 is legal (result 0, NX per rounding).
  - Out-of-range, NaN or inf → OF=1, NX=0, result per Configuration.
- DONE: `outValid`=1 with `intOut`/`flags` stable until `outReady`. Return to IDLE on the accept cycle.
- Magnitude register is INTW+1 bits wide to detect overflow before negation. The accumulator holds 16 bits above the shift range.

## Timing
- Reset values: `inReady`=0 during reset and 1 after reset release (IDLE); `outValid`=0; `intOut`=0; `flags`=3'b000; state IDLE; all datapath registers 0.
- Latency: accept edge at cycle 0 → `outValid` high from cycle N+2. Examples: 1.0 → N=10 → cycle 12; 0x7C00 → cycle 2.
- Throughput: one conversion in flight. `inReady` is 0 from the accept edge until DONE is accepted. Earliest next accept is the cycle after the `outValid && outReady` handshake.
- `outReady` held high through DONE: single-cycle `outValid` pulse.
- `inValid` during non-IDLE states is ignored; the source must hold the operand.
- Reset asserted mid-conversion: immediate return to reset values. The partial result is discarded and never presented.

## Configuration
- `FPU_CVT_SATURATE_EN` defined:
  - NaN and +overflow/+inf → max representable.
  - −overflow/−inf → min representable (unsigned: 0).
- Undefined: every OF case → `intOut`=0.
- OF flag is identical in both builds.

## Structure
- Shared package (with `fp16_t`, `opStatusFlag_t`, FP16 width macros): `cvtState_t` enum, `FP16_BIAS`=15, `FP16_FRACW`-derived shift constant 25 (`FP16_CVT_UNITY_EXP`).
- One sub-module, `fpu_cvt_rounder`: combinational RNE + negate + range check + saturation select. Inputs: magnitude, guard, sticky, sign, signedOut, special. Outputs: intOut, flags.
- The top contains only the FSM, shift counter and datapath registers.

## Test plan
- 0x3C00 (1.0), signed, INTW=32 → `intOut`=1, flags 000, `outValid` at cycle 12.
- 0x3E00 (1.5) → 2, NX=1. 0x4100 (2.5) → 2 (tie to even), NX=1. 0x4300 (3.5) → 4.
- 0xC500 (−5.0), signed → 0xFFFFFFFB, flags 000. Same input unsigned → 0, OF=1.
- 0x7C00 (+inf) → OF=1; saturate build 0x7FFFFFFF, non-saturate 0. 0x7BFF (65504), INTW=16, signed → OF, 0x7FFF (saturate).
- 0x0001 (subnormal) → 0, NX=1, `outValid` at cycle 15. `outReady` low for 5 cycles → outputs stable, `inReady`=0 throughout.
- Assert `rst_n` low at cycle 4 of a 1.0 conversion → `outValid`=0 and `inReady`=0 while in reset, `inReady`=1 after release. The next conversion of 0x4000 → 2 without residue.
